// File: rtl/camera_frame_writer.sv
// camera_frame_writer: streams CMOS pixels into one or two BRAM frame buffers,
// checks each frame's length and publishes the newest complete buffer.
module camera_frame_writer #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int PIX_W       = 16,
   parameter int NUM_BUFFERS = 2,
   parameter int ADDR_W      = 20,
   parameter int CNT_W       = 16
)(
   input  logic              p_clk,
   input  logic              sysrst_n,
   input  logic              cmos_config_done,
   input  logic              cmos_vsync,
   input  logic              cmos_pix_valid,
   input  logic [PIX_W-1:0]  cmos_pix_data,
   input  logic              capture_mode,
   input  logic              capture_arm,
   output logic              bram_write_enable,
   output logic [ADDR_W-1:0] bram_address,
   output logic [PIX_W-1:0]  bram_wdata,
   output logic              frame_ready,
   output logic              frame_buf_idx,
   output logic              frame_error,
   output logic [CNT_W-1:0]  frame_count,
   output logic              busy
);
   localparam int FP   = H_ACTIVE * V_ACTIVE;
   localparam int PC_W = $clog2(FP + 1);
   typedef enum logic [1:0] {IDLE, WAIT_START, CAPTURE, FINISH} state_t;
   state_t          r_state, w_next;
   logic            r_vsync, r_wbuf, r_armed, r_ovr;
   logic [PC_W-1:0] r_pix_cnt;
   logic            w_fall, w_rise, w_cap, w_accept, w_over, w_start, w_fin, w_good;
   assign w_fall   = r_vsync & ~cmos_vsync;
   assign w_rise   = ~r_vsync & cmos_vsync;
   assign w_cap    = cmos_config_done && r_state == CAPTURE && cmos_pix_valid;
   assign w_accept = w_cap && r_pix_cnt < PC_W'(FP);
   assign w_over   = w_cap && r_pix_cnt == PC_W'(FP);
   assign w_start  = cmos_config_done && r_state == WAIT_START && w_fall && (!capture_mode || r_armed);
   assign w_fin    = cmos_config_done && r_state == FINISH;
   assign w_good   = r_pix_cnt == PC_W'(FP) && !r_ovr;
   assign busy     = r_state == CAPTURE;
   always_comb begin
      w_next = r_state;
      if (!cmos_config_done) w_next = IDLE;
      else
         case (r_state)
            IDLE:       w_next = cmos_vsync ? WAIT_START : IDLE;
            WAIT_START: w_next = w_start ? CAPTURE : WAIT_START;
            CAPTURE:    w_next = w_rise ? FINISH : CAPTURE;
            default:    w_next = WAIT_START;
         endcase
   end
   always_ff @(posedge p_clk or negedge sysrst_n)
      if (!sysrst_n) r_state <= IDLE;
      else r_state <= w_next;
   always_ff @(posedge p_clk or negedge sysrst_n) begin
      if (!sysrst_n) begin
         r_vsync           <= 1'b0;
         r_wbuf            <= 1'b0;
         r_armed           <= 1'b0;
         r_ovr             <= 1'b0;
         r_pix_cnt         <= '0;
         bram_write_enable <= 1'b0;
         bram_address      <= '0;
         bram_wdata        <= '0;
         frame_ready       <= 1'b0;
         frame_error       <= 1'b0;
         frame_buf_idx     <= 1'b0;
         frame_count       <= '0;
      end else begin
         r_vsync           <= cmos_vsync;
         bram_write_enable <= w_accept;
         if (w_accept) begin
            bram_address <= (r_wbuf ? ADDR_W'(FP) : '0) + ADDR_W'(r_pix_cnt);
            bram_wdata   <= cmos_pix_data;
         end
         r_pix_cnt   <= (!cmos_config_done || w_start) ? '0 : r_pix_cnt + PC_W'(w_accept);
         r_ovr       <= w_start ? 1'b0 : (r_ovr | w_over);
         frame_ready <= w_fin && w_good;
         frame_error <= w_fin && !w_good;
         // a rejected single-shot frame keeps its arm so the next frame retries
         r_armed     <= (capture_arm && capture_mode) || (r_armed && !w_start) || (w_fin && !w_good && capture_mode);
         if (w_fin && w_good) begin
            frame_buf_idx <= r_wbuf;
            frame_count   <= frame_count + CNT_W'(1);
            if (NUM_BUFFERS == 2) r_wbuf <= ~r_wbuf;
         end
      end
   end
endmodule

// File: tb/tb_camera_frame_writer.sv
// tb_camera_frame_writer: frame-level reference model with cycle-stamped expected
// writes/status, compared against the DUT every cycle.
module tb_camera_frame_writer;
   localparam int H = 4, V = 2, FP = H * V, PW = 16, AW = 8, CW = 16;
   logic clk = 1'b0, rst_n = 1'b0;
   logic cfg = 1'b1, vs = 1'b0, pv = 1'b0, mode = 1'b0, arm = 1'b0;
   logic [PW-1:0] pd = '0;
   logic we, ready, idx, err, busy;
   logic [AW-1:0] addr;
   logic [PW-1:0] wdata;
   logic [CW-1:0] cnt;
   logic u1_we, u1_ready, u1_idx, u1_err, u1_busy;
   logic [AW-1:0] u1_addr;
   logic [PW-1:0] u1_wdata;
   logic [CW-1:0] u1_cnt;
   camera_frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(PW), .NUM_BUFFERS(2), .ADDR_W(AW), .CNT_W(CW)) dut (
      .p_clk(clk), .sysrst_n(rst_n), .cmos_config_done(cfg), .cmos_vsync(vs), .cmos_pix_valid(pv),
      .cmos_pix_data(pd), .capture_mode(mode), .capture_arm(arm), .bram_write_enable(we),
      .bram_address(addr), .bram_wdata(wdata), .frame_ready(ready), .frame_buf_idx(idx),
      .frame_error(err), .frame_count(cnt), .busy(busy));
   camera_frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(PW), .NUM_BUFFERS(1), .ADDR_W(AW), .CNT_W(CW)) u1 (
      .p_clk(clk), .sysrst_n(rst_n), .cmos_config_done(cfg), .cmos_vsync(vs), .cmos_pix_valid(pv),
      .cmos_pix_data(pd), .capture_mode(mode), .capture_arm(arm), .bram_write_enable(u1_we),
      .bram_address(u1_addr), .bram_wdata(u1_wdata), .frame_ready(u1_ready), .frame_buf_idx(u1_idx),
      .frame_error(u1_err), .frame_count(u1_cnt), .busy(u1_busy));
   always #5 clk = ~clk;

   typedef struct {int cyc; int a; int d;} wr_t;
   typedef struct {int cyc; bit good; int idx; int cnt;} st_t;
   wr_t wq[$];
   st_t sq[$];
   int  q1[$];
   int  cyc = 0, errors = 0, checks = 0;
   int  m_buf = 0, m_idx = 0, m_cnt = 0, e_idx = 0, e_cnt = 0, first_addr = -1;
   bit  m_armed = 0, m_seen = 0, m_single = 0, m_cfg = 1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      bit ew, es;
      ew = wq.size() > 0 && wq[0].cyc == cyc;
      chk("write_enable", int'(we), int'(ew));
      if (we && first_addr < 0) first_addr = int'(addr);
      if (ew) begin
         chk("address", int'(addr), wq[0].a);
         chk("wdata", int'(wdata), wq[0].d);
         void'(wq.pop_front());
      end
      es = sq.size() > 0 && sq[0].cyc == cyc;
      chk("frame_ready", int'(ready), int'(es && sq[0].good));
      chk("frame_error", int'(err), int'(es && !sq[0].good));
      if (es) begin
         if (sq[0].good) begin
            e_idx = sq[0].idx;
            e_cnt = sq[0].cnt;
         end
         void'(sq.pop_front());
      end
      chk("frame_buf_idx", int'(idx), e_idx);
      chk("frame_count", int'(cnt), e_cnt);
      if (u1_we) q1.push_back(int'(u1_addr));
   end

   task automatic step(input bit v, input bit p, input int d);
      @(posedge clk);
      #1;
      vs = v;
      pv = p;
      pd = d[PW-1:0];
   endtask

   task automatic frame(input int n, input int cfg_rise = -1, input int drop_at = -1, input bit rise_last = 0);
      bit cap;
      int d;
      for (int k = 0; k < 3; k++) step(1, 0, 0);
      if (m_cfg) m_seen = 1;
      step(0, 0, 0);
      cap = m_cfg && m_seen && (!m_single || m_armed);
      if (cap && m_single) m_armed = 0;
      for (int i = 0; i < n; i++) begin
         if (i == drop_at) begin
            step(0, 0, 0);
            cfg = 0; m_cfg = 0; m_seen = 0;
            step(0, 0, 0);
            step(0, 0, 0);
            step(0, 0, 0);
            cfg = 1; m_cfg = 1;
            return;
         end
         d = int'($urandom_range(0, 65535));
         step(rise_last && i == n - 1, 1, d);
         if (i == cfg_rise) begin cfg = 1; m_cfg = 1; end
         if (cap && i < FP) wq.push_back(wr_t'{cyc + 1, m_buf * FP + i, d});
         if (i % 3 == 2 && i != n - 1) step(0, 0, 0);
      end
      if (!rise_last) step(1, 0, 0);
      if (cap) begin
         if (n == FP) begin
            m_idx = m_buf;
            m_cnt++;
            m_buf ^= 1;
         end
         sq.push_back(st_t'{cyc + 2, n == FP, m_idx, m_cnt});
      end
      for (int k = 0; k < 3; k++) step(1, 0, 0);
   endtask

   task automatic reset_dut();
      #2;
      rst_n = 0;
      wq.delete(); sq.delete();
      m_buf = 0; m_idx = 0; m_cnt = 0; m_armed = 0; m_seen = 0;
      e_idx = 0; e_cnt = 0; first_addr = -1;
      #1;
      chk("rst_write_enable", int'(we), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_frame_count", int'(cnt), 0);
      chk("rst_frame_buf_idx", int'(idx), 0);
      step(vs, 0, 0);
      step(vs, 0, 0);
      rst_n = 1;
   endtask

   task automatic arm_pulse();
      step(1, 0, 0);
      arm = 1;
      if (m_single) m_armed = 1;
      step(1, 0, 0);
      arm = 0;
   endtask

   initial begin
      int d;
      #12;
      chk("init_write_enable", int'(we), 0);
      chk("init_address", int'(addr), 0);
      chk("init_ready", int'(ready), 0);
      chk("init_error", int'(err), 0);
      chk("init_busy", int'(busy), 0);
      step(0, 0, 0);
      rst_n = 1;
      // two clean frames, the second ending with a same-cycle pixel and vsync rise
      q1.delete();
      frame(8);
      frame(8, -1, -1, 1);
      chk("t1_frame_count", int'(cnt), 2);
      chk("t1_frame_buf_idx", int'(idx), 1);
      chk("nb1_frame_count", int'(u1_cnt), 2);
      chk("nb1_frame_buf_idx", int'(u1_idx), 0);
      chk("nb1_writes", q1.size(), 16);
      for (int i = 0; i < 16; i++) chk("nb1_address", i < q1.size() ? q1[i] : -1, i % 8);
      // short then long frame
      reset_dut();
      frame(7);
      frame(9);
      chk("t2_frame_count", int'(cnt), 0);
      chk("t2_frame_buf_idx", int'(idx), 0);
      // configuration completes mid-frame
      reset_dut();
      cfg = 0; m_cfg = 0;
      frame(8, 3);
      frame(8);
      chk("t3_first_address", first_addr, 0);
      chk("t3_frame_count", int'(cnt), 1);
      // single-shot capture
      reset_dut();
      mode = 1; m_single = 1;
      arm_pulse();
      frame(8);
      frame(8);
      frame(8);
      chk("t4_count_after_one_arm", int'(cnt), 1);
      arm_pulse();
      frame(8);
      chk("t4_frame_count", int'(cnt), 2);
      chk("t4_frame_buf_idx", int'(idx), 1);
      mode = 0; m_single = 0;
      // configuration lost mid-frame in buffer 1
      reset_dut();
      frame(8);
      frame(8, -1, 5);
      frame(8);
      chk("t5_frame_count", int'(cnt), 2);
      chk("t5_frame_buf_idx", int'(idx), 1);
      // asynchronous reset mid-frame, then the rest of that frame must be ignored
      reset_dut();
      for (int k = 0; k < 3; k++) step(1, 0, 0);
      m_seen = 1;
      step(0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         d = int'($urandom_range(0, 65535));
         step(0, 1, d);
         wq.push_back(wr_t'{cyc + 1, i, d});
      end
      chk("t6_busy", int'(busy), 1);
      reset_dut();
      for (int i = 0; i < 5; i++) step(0, 1, 100 + i);
      step(1, 0, 0);
      frame(8);
      chk("t6_first_address", first_addr, 0);
      chk("t6_frame_count", int'(cnt), 1);
      step(1, 0, 0);
      step(1, 0, 0);
      chk("pending_writes", wq.size(), 0);
      chk("pending_status", sq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
